// File: rtl/btn_debounce_pkg.sv
// Shared state encoding for the push-button debouncer.
// The four codes fill the 2-bit space; WAIT states differ from stable states in exactly one bit.
package btn_debounce_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_LOW    = 2'b00,
    S_WAIT_H = 2'b01,
    S_HIGH   = 2'b11,
    S_WAIT_L = 2'b10
  } state_t;

  function automatic logic is_wait(input state_t s);
    return (s == S_WAIT_H) || (s == S_WAIT_L);
  endfunction

endpackage

// File: rtl/btn_debouncer_if.sv
// Button-side bundle: raw level in, debounced level, edge strobes and busy out.
// slave is the debouncer; master is whoever drives the button and consumes the result.
interface btn_debouncer_if;
  logic btn_raw;
  logic btn_db;
  logic btn_rise;
  logic btn_fall;
  logic busy;

  modport master (
    output btn_raw,
    input  btn_db,
    input  btn_rise,
    input  btn_fall,
    input  busy
  );

  modport slave (
    input  btn_raw,
    output btn_db,
    output btn_rise,
    output btn_fall,
    output busy
  );
endinterface

// File: rtl/btn_debouncer_sync_ff_chain.sv
// Metastability synchroniser: STAGES-deep flop chain, q lags d by STAGES clocks.
// Free-running, no flow control; reset clears every stage.
module sync_ff_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain_q [STAGES];
  logic [WIDTH-1:0] chain_d [STAGES];

  always_comb begin
    chain_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      chain_d[i] = chain_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_q <= '{default: '0};
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/btn_debouncer.sv
// Debounces a raw button: synchroniser then counter-qualified 4-state FSM, all outputs registered.
// A new level is accepted SYNC_STAGES+STABLE_CYCLES clocks after it settles; no backpressure.
module btn_debouncer
  import btn_debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1000
) (
  input  logic            clk,
  input  logic            reset,
  btn_debouncer_if.slave  db_if
);

  localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_in;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  sync_ff_chain #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (db_if.btn_raw),
    .q     (sync_in)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      S_LOW: begin
        if (sync_in) begin
          state_d = S_WAIT_H;
          cnt_d   = '0;
        end
      end
      // Any reversal while qualifying drops back with no credit kept.
      S_WAIT_H: begin
        if (!sync_in) begin
          state_d = S_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          db_d    = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!sync_in) begin
          state_d = S_WAIT_L;
          cnt_d   = '0;
        end
      end
      S_WAIT_L: begin
        if (sync_in) begin
          state_d = S_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          db_d    = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
        db_d    = 1'b0;
      end
    endcase
    // busy is registered off the next state so it lines up with state_q.
    busy_d = is_wait(state_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign db_if.btn_db   = db_q;
  assign db_if.btn_rise = rise_q;
  assign db_if.btn_fall = fall_q;
  assign db_if.busy     = busy_q;

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer with SYNC_STAGES=2, STABLE_CYCLES=4 (accept at edge k+6).
// Outputs are sampled 1ns after each rising edge; inputs change at that same point.
module tb_btn_debouncer;
  import btn_debounce_pkg::*;

  logic clk = 1'b0;
  logic reset;
  btn_debouncer_if bif();

  always #5 clk = ~clk;

  btn_debouncer #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .db_if (bif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller sets btn_raw before this; the first edge here is sampling edge k (o=0).
  task automatic run_qual(input string tag, input bit rising);
    for (int o = 0; o <= 8; o++) begin
      step();
      chk($sformatf("%s db o=%0d", tag, o), 8'(bif.btn_db), 8'(rising ? (o >= 6) : (o < 6)));
      chk($sformatf("%s rise o=%0d", tag, o), 8'(bif.btn_rise), 8'(rising && o == 6));
      chk($sformatf("%s fall o=%0d", tag, o), 8'(bif.btn_fall), 8'(!rising && o == 6));
      if (o >= 1)
        chk($sformatf("%s busy o=%0d", tag, o), 8'(bif.busy), 8'(o >= 2 && o < 6));
    end
  endtask

  bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    reset       = 1'b1;
    bif.btn_raw = 1'b1;

    // 1: reset held with button high, then full qualification after release
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t1 rst outs c%0d", i),
          8'({bif.btn_db, bif.btn_rise, bif.btn_fall, bif.busy}), 8'h0);
    end
    chk("t1 rst state", 8'(dut.state_q), 8'(S_LOW));
    reset = 1'b0;
    run_qual("t1", 1'b1);

    // 5a: clean release from S_HIGH
    bif.btn_raw = 1'b0;
    run_qual("t5_rel", 1'b0);

    // 2: clean press
    bif.btn_raw = 1'b1;
    run_qual("t2", 1'b1);

    // 5b: two-cycle low glitch while high gives no fall
    for (int i = 0; i < 10; i++) begin
      bif.btn_raw = (i >= 2);
      step();
      chk($sformatf("t5g fall i=%0d", i), 8'(bif.btn_fall), 8'h0);
      chk($sformatf("t5g db i=%0d", i), 8'(bif.btn_db), 8'h1);
      chk($sformatf("t5g busy i=%0d", i), 8'(bif.busy), 8'(i == 2 || i == 3));
    end

    bif.btn_raw = 1'b0;
    run_qual("t5_rel2", 1'b0);

    // 3: three-cycle high glitch from S_LOW is rejected
    for (int i = 0; i < 10; i++) begin
      bif.btn_raw = (i < 3);
      step();
      chk($sformatf("t3 rise i=%0d", i), 8'(bif.btn_rise), 8'h0);
      chk($sformatf("t3 db i=%0d", i), 8'(bif.btn_db), 8'h0);
      chk($sformatf("t3 busy i=%0d", i), 8'(bif.busy), 8'(i >= 2 && i <= 4));
    end
    chk("t3 state", 8'(dut.state_q), 8'(S_LOW));

    // 4: bounce 1,0,1,1,0 then held high from edge m
    for (int i = 0; i < 5; i++) begin
      bif.btn_raw = pat[i];
      step();
      chk($sformatf("t4 bounce rise i=%0d", i), 8'(bif.btn_rise), 8'h0);
      chk($sformatf("t4 bounce db i=%0d", i), 8'(bif.btn_db), 8'h0);
    end
    bif.btn_raw = 1'b1;
    run_qual("t4", 1'b1);

    // 6: reset in the middle of S_WAIT_H
    bif.btn_raw = 1'b0;
    run_qual("t6_pre", 1'b0);
    bif.btn_raw = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("t6 pre busy", 8'(bif.busy), 8'h1);
    chk("t6 pre cnt", 8'(dut.cnt_q), 8'd2);
    reset = 1'b1;
    #1;
    chk("t6 async busy", 8'(bif.busy), 8'h0);
    chk("t6 async db", 8'(bif.btn_db), 8'h0);
    chk("t6 async state", 8'(dut.state_q), 8'(S_LOW));
    chk("t6 async cnt", 8'(dut.cnt_q), 8'd0);
    step();
    reset = 1'b0;
    run_qual("t6", 1'b1);

    // Reset while high drops btn_db without a clock edge
    reset = 1'b1;
    #2;
    chk("t6 high async db", 8'(bif.btn_db), 8'h0);
    chk("t6 high async rise", 8'(bif.btn_rise), 8'h0);
    step();
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/btn_debouncer.md
Name: btn_debouncer

Overview:
Conditions a raw, asynchronous, bouncing push-button or switch input into a clean, clock-synchronous level. Its btn_db output drives the bi input of fsm_mealy, the downstream edge-detector stage. The block provides a multi-flop synchroniser followed by a counter-qualified 4-state debounce FSM. It also emits one-cycle rise/fall strobes for consumers that need edges directly.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops; legal range >= 2.
STABLE_CYCLES, 1000, consecutive clk cycles the synchronised input must hold a new value before it is accepted; legal range >= 1.
CNT_W, $clog2(STABLE_CYCLES+1), counter width; derived localparam, not user-set.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  asynchronous, active-high reset.
btn_raw  in  1  raw asynchronous button/switch level.
btn_db  out  1  debounced, registered level.
btn_rise  out  1  one-cycle strobe when btn_db goes 0->1.
btn_fall  out  1  one-cycle strobe when btn_db goes 1->0.
busy  out  1  high while a candidate change is being qualified (FSM in a WAIT state).

Behaviour:
- Reset:
  - Asynchronous, active-high reset on reset; clock clk.
  - While reset is high: all synchroniser flops=0, cnt=0, state=S_LOW, btn_db=0, btn_rise=0, btn_fall=0, busy=0.
- Synchroniser:
  - SYNC_STAGES-deep shift chain; sync_in is the last flop.
  - No other logic may touch btn_raw.
- FSM encoding: S_LOW=2'b00, S_WAIT_H=2'b01, S_HIGH=2'b11, S_WAIT_L=2'b10. Unused codes: none (2 bits fully used). The default branch still forces S_LOW.
- S_LOW:
  - sync_in=1 -> S_WAIT_H, cnt<=0.
  - Otherwise stay.
- S_WAIT_H:
  - sync_in=0 -> S_LOW (glitch rejected, no strobe).
  - Else if cnt==STABLE_CYCLES-1 -> S_HIGH, btn_db<=1, btn_rise<=1.
  - Else cnt<=cnt+1.
- S_HIGH: mirror of S_LOW. sync_in=0 -> S_WAIT_L, cnt<=0.
- S_WAIT_L: mirror of S_WAIT_H.
  - sync_in=1 -> S_HIGH (no strobe).
  - Qualified -> S_LOW, btn_db<=0, btn_fall<=1.
- Outputs:
  - All outputs are registered (Moore-style); no combinational path from btn_raw.
  - btn_rise and btn_fall are high for exactly one cycle, default 0 every cycle. They are never both high.
  - busy=1 iff state is S_WAIT_H or S_WAIT_L.
- Latency: btn_raw stable from sampling edge k -> btn_db/strobe updated at edge k+SYNC_STAGES+STABLE_CYCLES.
- Bounce: any reversal during WAIT returns to the stable state. The next change restarts the counter from 0; there is no partial credit.
- cnt never exceeds STABLE_CYCLES-1; no wrap-around is possible.
- Reset mid-qualification:
  - Immediate return to the reset state.
  - If btn_raw is high at reset release, a full qualification runs and a btn_rise strobe is produced.

Decomposition:
- btn_debounce_pkg holds the state localparams S_LOW/S_WAIT_H/S_HIGH/S_WAIT_L and the 2-bit state width.
- One sub-module, sync_ff_chain (params WIDTH=1, STAGES; async-reset shift chain).
- The top instantiates sync_ff_chain, then the FSM/counter.

Test Plan:
All scenarios use SYNC_STAGES=2, STABLE_CYCLES=4.
1. Reset held 3 cycles with btn_raw=1 -> btn_db=btn_rise=btn_fall=busy=0 throughout. After release, btn_rise pulses once at edge 6 after release.
2. Clean press: btn_raw 0->1 sampled at edge k and held -> busy=1 from edge k+2; btn_db=1 and btn_rise=1 at edge k+6; btn_rise=0 at k+7; busy=0 at k+6.
3. Glitch: btn_raw=1 for 3 cycles then 0 -> btn_db stays 0, no btn_rise, busy returns to 0, state=S_LOW.
4. Bounce: btn_raw pattern 1,0,1,1,0, then 1 held from edge m -> btn_db=1 exactly at edge m+6; only one btn_rise pulse.
5. Release from S_HIGH: btn_raw 1->0 held from edge k -> btn_db=0 and btn_fall=1 at edge k+6; a 2-cycle low glitch instead yields no btn_fall.
6. Reset asserted mid-S_WAIT_H (cnt=2) -> busy/btn_db drop immediately without waiting for clk. With btn_raw still high after release, btn_rise appears 6 edges after release.
